sram_port_arbiter: RTL and testbench

- Shares the single-port, synchronous-read (1-cycle latency) frame SRAM between two requesters.
  - The 3x3 window reader: read-only, issues one-cycle chip-select pulses, and stalls on a busy input.
  - A frame writer: the pixel loader or result write-back, with a request/ack handshake.
- Stalls the reader through its busy input while the writer owns the port.
- Holds the last read word stable, so a stalled reader still samples correct data.

---
 rtl/sram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous-read frame SRAM between a stallable window reader and a
// request/ack frame writer; the last read word is held for a stalled reader.
module sram_port_arbiter #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 17,
  parameter int WAIT_MAX = 8,
  parameter int WR_BURST = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iRdEn,
  input  logic              iRdCs,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData,
  output logic              oRdBusy,
  input  logic              iWrReq,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrAck,
  output logic              oMemCs,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oErr
);

  localparam int WAIT_W  = $clog2(WAIT_MAX + 1);
  localparam int BURST_W = $clog2(WR_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_TOP   = WAIT_W'(WAIT_MAX);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(WR_BURST - 1);

  typedef enum logic [1:0] {
    S_RD    = 2'd0,
    S_DRAIN = 2'd1,
    S_WR    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [BURST_W-1:0]  w_burst_nxt;
  logic                r_rd_pend;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_hold;
  logic                w_err_set;
  logic                w_rd_issue;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    w_burst_nxt = r_burst_cnt;
    w_err_set   = 1'b0;
    oMemCs      = 1'b0;
    oMemWe      = 1'b0;
    oMemAddr    = '0;
    oMemWData   = '0;
    oWrAck      = 1'b0;
    case (r_state)
      S_RD: begin
        oMemCs   = iRdCs;
        oMemAddr = iRdAddr;
        if (iWrReq) begin
          w_wait_nxt = (r_wait_cnt == WAIT_TOP) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
          if (!iRdEn || r_wait_cnt == WAIT_TOP) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // A CS decided before busy rose is still in flight and must be served.
        oMemCs      = iRdCs;
        oMemAddr    = iRdAddr;
        w_burst_nxt = '0;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_err_set = iRdCs;
        if (iWrReq) begin
          oMemCs      = 1'b1;
          oMemWe      = 1'b1;
          oMemAddr    = iWrAddr;
          oMemWData   = iWrData;
          oWrAck      = 1'b1;
          w_burst_nxt = r_burst_cnt + BURST_W'(1);
          if (r_burst_cnt == BURST_LAST) begin
            w_state_nxt = S_RD;
          end
        end else begin
          w_state_nxt = S_RD;
        end
      end
      default: w_state_nxt = S_RD;
    endcase
  end

  assign w_rd_issue = oMemCs && !oMemWe;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= S_RD;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_busy      <= (w_state_nxt != S_RD);
      r_err       <= r_err | w_err_set;
      r_rd_pend   <= w_rd_issue;
      // Captured even during a write cycle, so a read launched in drain is kept.
      if (r_rd_pend) begin
        r_hold <= iMemRData;
      end
    end
  end

  assign oRdData = r_rd_pend ? iMemRData : r_hold;
  assign oRdBusy = r_busy;
  assign oErr    = r_err;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, legal reader/writer models and a
// reference memory that predicts read data, grant latency and burst length.
module tb_sram_port_arbiter;

  localparam int DW       = 24;
  localparam int AW       = 17;
  localparam int WAIT_MAX = 8;
  localparam int WR_BURST = 16;
  // Worst case: WAIT_MAX+1 cycles waiting in S_RD, one drain cycle, then the ack.
  localparam int MAX_PEND = WAIT_MAX + 3;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iRdEn;
  logic          iRdCs;
  logic [AW-1:0] iRdAddr;
  logic [DW-1:0] oRdData;
  logic          oRdBusy;
  logic          iWrReq;
  logic [AW-1:0] iWrAddr;
  logic [DW-1:0] iWrData;
  logic          oWrAck;
  logic          oMemCs;
  logic          oMemWe;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemWData;
  logic [DW-1:0] iMemRData;
  logic          oErr;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  sram_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .WAIT_MAX(WAIT_MAX), .WR_BURST(WR_BURST)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iRdEn(iRdEn), .iRdCs(iRdCs), .iRdAddr(iRdAddr),
    .oRdData(oRdData), .oRdBusy(oRdBusy),
    .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrAck(oWrAck),
    .oMemCs(oMemCs), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .iMemRData(iMemRData), .oErr(oErr)
  );

  function automatic logic [DW-1:0] init_val(int a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return (a == 5) ? 24'hA1B2C3 : h[27:4];
  endfunction

  // SRAM model: 1-cycle read latency, garbage on the bus when not reading.
  logic [DW-1:0] sram [0:1023];
  bit            mem_inited;
  always @(posedge iClk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
      mem_inited <= 1'b1;
    end else if (oMemCs && oMemWe) begin
      sram[oMemAddr[9:0]] <= oMemWData;
    end
    if (oMemCs && !oMemWe) iMemRData <= sram[oMemAddr[9:0]];
    else                   iMemRData <= DW'($urandom);
  end

  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] exp_hold;
  logic [DW-1:0] rd_exp_val;
  bit            rd_exp_valid;
  bit            prev_busy;
  bit            rd_illegal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge iClk);
    #1;
  endtask

  // Called after the inputs of a cycle are set: checks the read path every cycle.
  task automatic settle();
    #1;
    if (rd_exp_valid) exp_hold = rd_exp_val;
    rd_exp_valid = 1'b0;
    chk("rd_data", 32'(oRdData), 32'(exp_hold));
    if (iRdCs && !rd_illegal) begin
      chk("rd_cs_pass", {30'd0, oMemCs, oMemWe}, 32'd2);
      chk("rd_addr", 32'(oMemAddr), 32'(iRdAddr));
      rd_exp_valid = 1'b1;
      rd_exp_val   = ref_mem[iRdAddr[9:0]];
    end
    prev_busy = oRdBusy;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    iRdEn = 1'b0; iRdCs = 1'b0; iRdAddr = '0;
    iWrReq = 1'b0; iWrAddr = '0; iWrData = '0;
    rd_illegal = 1'b0;
    #1;
    exp_hold = '0; rd_exp_valid = 1'b0; prev_busy = 1'b0;
    chk("rst_busy", 32'(oRdBusy), 0);
    chk("rst_cs", 32'(oMemCs), 0);
    chk("rst_we", 32'(oMemWe), 0);
    chk("rst_ack", 32'(oWrAck), 0);
    chk("rst_rddata", 32'(oRdData), 0);
    chk("rst_err", 32'(oErr), 0);
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;
  endtask

  task automatic idle(input int n);
    iRdCs = 1'b0; iWrReq = 1'b0;
    for (int i = 0; i < n; i++) begin next_cycle(); settle(); end
  endtask

  // rd_mode 0: random CS, 1: CS every other permitted cycle.
  task automatic traffic(input int ncyc, input int rd_mode, input int words, input int gap_pct,
                         input bit en_toggle, output int acks, output int max_run, output int first_pend);
    int  run, pend, left;
    bit  wr_active, phase, want;
    acks = 0; max_run = 0; first_pend = -1;
    run = 0; pend = 0; left = words; wr_active = 1'b0; phase = 1'b1;
    iRdEn = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      next_cycle();
      if (en_toggle && $urandom_range(0, 15) == 0) iRdEn = ~iRdEn;
      if (rd_mode == 1) begin want = phase; phase = ~phase; end
      else want = ($urandom_range(0, 2) == 0);
      iRdCs   = iRdEn && !prev_busy && want;
      iRdAddr = AW'($urandom_range(0, 1023));
      if (!wr_active && left > 0 && $urandom_range(0, 99) >= gap_pct) begin
        wr_active = 1'b1; left--; pend = 0;
        iWrAddr = AW'($urandom_range(0, 1023));
        iWrData = DW'($urandom);
      end
      iWrReq = wr_active;
      settle();
      chk("no_err", 32'(oErr), 0);
      if (wr_active) pend++;
      if (oWrAck) begin
        chk("ack_req", 32'(wr_active), 1);
        chk("ack_cs_we", {30'd0, oMemCs, oMemWe}, 32'd3);
        chk("ack_addr", 32'(oMemAddr), 32'(iWrAddr));
        chk("ack_wdata", 32'(oMemWData), 32'(iWrData));
        chk("ack_no_rd", 32'(iRdCs), 0);
        chk("ack_busy", 32'(oRdBusy), 1);
        chk("wait_bound", 32'(pend <= MAX_PEND), 1);
        if (first_pend < 0) first_pend = pend;
        ref_mem[iWrAddr[9:0]] = iWrData;
        acks++; run++;
        chk("burst_bound", 32'(run <= WR_BURST), 1);
        if (run > max_run) max_run = run;
        wr_active = 1'b0;
      end else begin
        run = 0;
      end
    end
    iWrReq = 1'b0; iRdCs = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d [0:2];
    int acks, max_run, first_pend;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    iRst = 1'b1;
    do_reset();
    idle(2);

    // Reader only: one CS, data held with no further CS.
    next_cycle();
    iRdEn = 1'b1; iRdCs = 1'b1; iRdAddr = AW'(5);
    settle();
    chk("ro_cs", 32'(oMemCs), 1);
    chk("ro_we", 32'(oMemWe), 0);
    next_cycle();
    iRdCs = 1'b0;
    settle();
    chk("ro_data", 32'(oRdData), 32'h00A1B2C3);
    idle(10);
    chk("ro_hold", 32'(oRdData), 32'h00A1B2C3);

    // Writer with reader disabled: 3 words at 0x100..0x102.
    for (int k = 0; k < 3; k++) d[k] = DW'($urandom);
    next_cycle();
    iRdEn = 1'b0; iWrReq = 1'b1; iWrAddr = AW'(17'h100); iWrData = d[0];
    settle();
    chk("w3_busy_pre", 32'(oRdBusy), 0);
    chk("w3_ack_pre", 32'(oWrAck), 0);
    next_cycle();
    settle();
    chk("w3_drain_busy", 32'(oRdBusy), 1);
    chk("w3_drain_ack", 32'(oWrAck), 0);
    chk("w3_drain_cs", 32'(oMemCs), 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      iWrAddr = AW'(17'h100 + k); iWrData = d[k];
      settle();
      chk("w3_ack", 32'(oWrAck), 1);
      chk("w3_we", 32'(oMemWe), 1);
      chk("w3_addr", 32'(oMemAddr), 32'h100 + k);
      chk("w3_wdata", 32'(oMemWData), 32'(d[k]));
      ref_mem[10'h100 + k] = d[k];
    end
    next_cycle();
    iWrReq = 1'b0;
    settle();
    chk("w3_idle_ack", 32'(oWrAck), 0);
    chk("w3_idle_busy", 32'(oRdBusy), 1);
    next_cycle();
    settle();
    chk("w3_busy_fall", 32'(oRdBusy), 0);
    next_cycle();
    iRdEn = 1'b1; iRdCs = 1'b1; iRdAddr = AW'(17'h101);
    settle();
    next_cycle();
    iRdCs = 1'b0;
    settle();
    chk("w3_readback", 32'(oRdData), 32'(d[1]));

    // Starvation bound and burst limit: reader CS every 2 cycles, 40 held words.
    idle(3);
    traffic(300, 1, 40, 0, 1'b0, acks, max_run, first_pend);
    chk("burst_acks", 32'(acks), 40);
    chk("burst_len", 32'(max_run), WR_BURST);
    chk("first_grant", 32'(first_pend), MAX_PEND);
    idle(3);

    // Randomised mix with reader enable toggling.
    traffic(2000, 0, 100, 40, 1'b1, acks, max_run, first_pend);
    chk("rand_acks", 32'(acks), 100);
    idle(3);

    // Violation: reader CS during a write cycle.
    next_cycle();
    iRdEn = 1'b0; iWrReq = 1'b1; iWrAddr = AW'(17'h2AA); iWrData = DW'($urandom);
    settle();
    next_cycle();
    settle();
    next_cycle();
    rd_illegal = 1'b1; iRdCs = 1'b1; iRdAddr = AW'(17'h055);
    settle();
    chk("viol_ack", 32'(oWrAck), 1);
    chk("viol_we", 32'(oMemWe), 1);
    chk("viol_addr", 32'(oMemAddr), 32'h2AA);
    chk("viol_wdata", 32'(oMemWData), 32'(iWrData));
    ref_mem[10'h2AA] = iWrData;
    next_cycle();
    rd_illegal = 1'b0; iRdCs = 1'b0; iWrReq = 1'b0;
    settle();
    chk("err_set", 32'(oErr), 1);
    idle(5);
    chk("err_sticky", 32'(oErr), 1);

    // Reset mid-burst clears busy and the error flag.
    next_cycle();
    iWrReq = 1'b1; iWrAddr = AW'(17'h3C3); iWrData = DW'($urandom);
    settle();
    next_cycle();
    settle();
    next_cycle();
    settle();
    chk("mid_busy", 32'(oRdBusy), 1);
    do_reset();
    idle(2);
    chk("post_rst_busy", 32'(oRdBusy), 0);
    chk("post_rst_err", 32'(oErr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
